// File: rtl/fft_operand_loader.sv
// Operand loader for the radix-2 butterfly: debounced button captures six switch operands, then hands them off via valid/ready.
// Optional macro TWIDDLE_CLAMP_EN saturates a -128 twiddle capture (rew/imw) to -127.
module fft_operand_loader #(
  parameter int unsigned DEB_CYCLES  = 3,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] SW,
  input  logic       load_btn,
  input  logic       out_ready,
  output logic       out_valid,
  output logic [7:0] rew,
  output logic [7:0] imw,
  output logic [7:0] reb,
  output logic [7:0] imb,
  output logic [7:0] rea,
  output logic [7:0] ima,
  output logic [2:0] slot
);

  typedef enum logic {COLLECT, FULL} state_t;

  state_t                 state_q, state_d;
  logic [SYNC_STAGES-1:0] sync_q;
  logic                   btn_s;
  logic [7:0]             cnt_q;
  logic                   deb_q, deb_prev_q;
  logic                   press;
  logic [2:0]             slot_d;
  logic                   cap_en;
  logic                   clamp;
  logic [7:0]             cap_val;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) sync_q <= '0;
    else        sync_q <= {sync_q[SYNC_STAGES-2:0], load_btn};
  end

  assign btn_s = sync_q[SYNC_STAGES-1];

  // deb only follows btn_s after DEB_CYCLES consecutive disagreeing samples
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_q      <= '0;
      deb_q      <= 1'b0;
      deb_prev_q <= 1'b0;
    end else begin
      deb_prev_q <= deb_q;
      if (btn_s == deb_q) begin
        cnt_q <= '0;
      end else if (cnt_q == 8'(DEB_CYCLES - 1)) begin
        deb_q <= btn_s;
        cnt_q <= '0;
      end else begin
        cnt_q <= cnt_q + 8'd1;
      end
    end
  end

  assign press = deb_q & ~deb_prev_q;

  always_comb begin
    state_d = state_q;
    slot_d  = slot;
    cap_en  = 1'b0;
    case (state_q)
      COLLECT: begin
        if (press) begin
          cap_en = 1'b1;
          if (slot == 3'd5) begin
            slot_d  = 3'd6;
            state_d = FULL;
          end else begin
            slot_d = slot + 3'd1;
          end
        end
      end
      FULL: begin
        if (out_ready) begin
          slot_d  = 3'd0;
          state_d = COLLECT;
        end
      end
      default: state_d = COLLECT;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= COLLECT;
      slot    <= '0;
    end else begin
      state_q <= state_d;
      slot    <= slot_d;
    end
  end

  assign out_valid = (state_q == FULL);

`ifdef TWIDDLE_CLAMP_EN
  assign clamp = (slot <= 3'd1) && (SW == 8'h80);
`else
  assign clamp = 1'b0;
`endif

  assign cap_val = clamp ? 8'h81 : SW;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rew <= '0;
      imw <= '0;
      reb <= '0;
      imb <= '0;
      rea <= '0;
      ima <= '0;
    end else if (cap_en) begin
      case (slot)
        3'd0:    rew <= cap_val;
        3'd1:    imw <= cap_val;
        3'd2:    reb <= cap_val;
        3'd3:    imb <= cap_val;
        3'd4:    rea <= cap_val;
        3'd5:    ima <= cap_val;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_fft_operand_loader.sv
// Scoreboard bench for fft_operand_loader: expected banks queued by stimulus, checked when out_valid rises.
module tb_fft_operand_loader;

  logic       clk;
  logic       reset;
  logic [7:0] SW;
  logic       load_btn;
  logic       out_ready;
  logic       out_valid;
  logic [7:0] rew, imw, reb, imb, rea, ima;
  logic [2:0] slot;

  int unsigned n_cmp = 0;
  int unsigned n_err = 0;
  logic [47:0] exp_q[$];
  logic        prev_valid;

  fft_operand_loader #(.DEB_CYCLES(3), .SYNC_STAGES(2)) dut (
    .clk(clk), .reset(reset), .SW(SW), .load_btn(load_btn), .out_ready(out_ready),
    .out_valid(out_valid), .rew(rew), .imw(imw), .reb(reb), .imb(imb),
    .rea(rea), .ima(ima), .slot(slot)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %02h expected %02h at %0t", nm, act, exp, $time);
    end
  endtask

  // Monitor: each new presentation of a full bank consumes one expected entry
  initial begin
    string nms[6];
    logic [47:0] got, e;
    nms = '{"rew", "imw", "reb", "imb", "rea", "ima"};
    prev_valid = 1'b0;
    forever begin
      @(negedge clk);
      if (out_valid === 1'b1 && prev_valid !== 1'b1) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_valid", {7'd0, out_valid}, 8'h00);
        end else begin
          e   = exp_q.pop_front();
          got = {rew, imw, reb, imb, rea, ima};
          chk("full_slot", {5'd0, slot}, 8'h06);
          for (int i = 0; i < 6; i++)
            chk(nms[i], got[47-8*i -: 8], e[47-8*i -: 8]);
        end
      end
      prev_valid = out_valid;
    end
  end

  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic press_btn(input logic [7:0] v);
    SW = v;
    load_btn = 1'b1;
    cycles(10);
    load_btn = 1'b0;
    cycles(10);
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_valid"}, {7'd0, out_valid}, 8'h00);
    chk({tag, "_slot"}, {5'd0, slot}, 8'h00);
    chk({tag, "_rew"}, rew, 8'h00);
    chk({tag, "_imw"}, imw, 8'h00);
    chk({tag, "_reb"}, reb, 8'h00);
    chk({tag, "_imb"}, imb, 8'h00);
    chk({tag, "_rea"}, rea, 8'h00);
    chk({tag, "_ima"}, ima, 8'h00);
  endtask

  initial begin
    logic [7:0] tw;
    reset = 1'b0; SW = 8'h00; load_btn = 1'b0; out_ready = 1'b0;
    cycles(3);
    check_zero("reset");
    reset = 1'b1;
    cycles(2);

    // First bank, out_ready low, held for 20 cycles
    exp_q.push_back({8'h40, 8'h00, 8'h20, 8'hE0, 8'h10, 8'hF0});
    press_btn(8'h40); press_btn(8'h00); press_btn(8'h20);
    press_btn(8'hE0); press_btn(8'h10); press_btn(8'hF0);
    cycles(20);
    chk("hold_valid", {7'd0, out_valid}, 8'h01);
    chk("hold_slot", {5'd0, slot}, 8'h06);
    chk("hold_rew", rew, 8'h40);
    chk("hold_imb", imb, 8'hE0);
    chk("hold_ima", ima, 8'hF0);

    // Single-cycle transfer
    out_ready = 1'b1;
    cycles(1);
    out_ready = 1'b0;
    chk("xfer_valid", {7'd0, out_valid}, 8'h00);
    chk("xfer_slot", {5'd0, slot}, 8'h00);
    chk("xfer_rew", rew, 8'h40);
    chk("xfer_ima", ima, 8'hF0);

    // Seven presses: the seventh lands in FULL and is dropped
    exp_q.push_back({8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66});
    press_btn(8'h11); press_btn(8'h22); press_btn(8'h33);
    press_btn(8'h44); press_btn(8'h55); press_btn(8'h66);
    press_btn(8'h77);
    chk("p7_valid", {7'd0, out_valid}, 8'h01);
    chk("p7_slot", {5'd0, slot}, 8'h06);
    chk("p7_rew", rew, 8'h11);
    chk("p7_ima", ima, 8'h66);

    // Press aligned with the transfer edge (press arrives 5 edges after load_btn rises)
    SW = 8'h99;
    load_btn = 1'b1;
    cycles(5);
    out_ready = 1'b1;
    cycles(1);
    out_ready = 1'b0;
    chk("coinc_valid", {7'd0, out_valid}, 8'h00);
    chk("coinc_slot", {5'd0, slot}, 8'h00);
    chk("coinc_rew", rew, 8'h11);
    cycles(10);
    chk("held_slot", {5'd0, slot}, 8'h00);
    chk("held_rew", rew, 8'h11);
    load_btn = 1'b0;
    cycles(10);

    // Bounce shorter than the debounce window, then a stable press
    SW = 8'h5A;
    for (int i = 0; i < 10; i++) begin
      load_btn = (i % 2 == 0);
      cycles(1);
    end
    chk("bounce_slot", {5'd0, slot}, 8'h00);
    load_btn = 1'b1;
    cycles(10);
    chk("bounce_slot1", {5'd0, slot}, 8'h01);
    chk("bounce_rew", rew, 8'h5A);
    load_btn = 1'b0;
    cycles(10);

    // Three more captures then a one-cycle reset pulse drops the partial bank
    press_btn(8'h01); press_btn(8'h02); press_btn(8'h03);
    chk("partial_slot", {5'd0, slot}, 8'h04);
    chk("partial_imb", imb, 8'h03);
    reset = 1'b0;
    #1;
    check_zero("midrst");
    cycles(1);
    reset = 1'b1;
    cycles(1);
    press_btn(8'h7E);
    chk("after_rst_slot", {5'd0, slot}, 8'h01);
    chk("after_rst_rew", rew, 8'h7E);
    chk("after_rst_imw", imw, 8'h00);

    // -128 on every operand; only twiddles clamp when the feature is built in
    reset = 1'b0;
    cycles(1);
    reset = 1'b1;
    cycles(1);
`ifdef TWIDDLE_CLAMP_EN
    tw = 8'h81;
`else
    tw = 8'h80;
`endif
    exp_q.push_back({tw, tw, 8'h80, 8'h80, 8'h80, 8'h80});
    for (int i = 0; i < 6; i++) press_btn(8'h80);
    out_ready = 1'b1;
    cycles(2);
    out_ready = 1'b0;
    chk("final_valid", {7'd0, out_valid}, 8'h00);
    cycles(3);
    chk("queue_drained", 8'(exp_q.size()), 8'h00);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not finish, expected completion");
    $fatal(1, "timeout");
  end

endmodule
